// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state encoding and small op-decode helpers.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } md_state_e;

  localparam int CNT_W = 6;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Combinational conditional two's-complement negator, shared by operand
// magnitude extraction and result sign fixup.
module muldiv_negate #(
  parameter int N = 32
) (
  input  logic [N-1:0] val_i,
  input  logic         neg_i,
  output logic [N-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + N'(1)) : val_i;

endmodule

// File: rtl/muldiv.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with sign fixup and a one-cycle HI/LO write strobe.
//
// state | meaning
// IDLE  | waiting for start; drops busy/hilo_we after the write cycle
// CALC  | WIDTH iterations of shift-add or restoring divide
// FIX   | apply result signs, register {HI,LO}
// DONE  | raise hilo_we for the following cycle, then back to IDLE
module muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cancel,
  output logic               busy,
  output logic               hilo_we,
  output logic [2*WIDTH-1:0] hilo_o
);

  md_state_e          state_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               sa_q, sb_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               busy_q, hilo_we_q;
  logic [2*WIDTH-1:0] hilo_q;

  logic               in_signed, sa_in, sb_in;
  logic [WIDTH-1:0]   a_mag, b_mag;

  assign in_signed = op_is_signed(op);
  assign sa_in     = in_signed & a[WIDTH-1];
  assign sb_in     = in_signed & b[WIDTH-1];

  muldiv_negate #(.N(WIDTH)) u_neg_a (.val_i(a), .neg_i(sa_in), .val_o(a_mag));
  muldiv_negate #(.N(WIDTH)) u_neg_b (.val_i(b), .neg_i(sb_in), .val_o(b_mag));

  // Accumulator holds {hi, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  logic [WIDTH:0] mul_sum, div_shift, div_diff;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, b_q};
    acc_d     = acc_q;
    if (op_is_div(op_q)) begin
      if (div_diff[WIDTH]) acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      else                 acc_d = {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  logic               op_signed_q, b_zero;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [2*WIDTH-1:0] result;

  assign op_signed_q = op_is_signed(op_q);
  assign b_zero      = (b_q == '0);

  muldiv_negate #(.N(2*WIDTH)) u_neg_prod (
    .val_i(acc_q), .neg_i(op_signed_q & (sa_q ^ sb_q)), .val_o(prod_fix));
  // Divide-by-zero keeps the all-ones quotient; the remainder path restores raw a.
  muldiv_negate #(.N(WIDTH)) u_neg_quo (
    .val_i(acc_q[WIDTH-1:0]), .neg_i(op_signed_q & (sa_q ^ sb_q) & ~b_zero), .val_o(quo_fix));
  muldiv_negate #(.N(WIDTH)) u_neg_rem (
    .val_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(op_signed_q & sa_q), .val_o(rem_fix));

  assign result = op_is_div(op_q) ? {rem_fix, quo_fix} : prod_fix;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      busy_q    <= 1'b0;
      hilo_we_q <= 1'b0;
      hilo_q    <= '0;
    end else if (cancel) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hilo_we_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          hilo_we_q <= 1'b0;
          busy_q    <= 1'b0;
          if (start && !busy_q) begin
            op_q    <= op;
            a_q     <= a_mag;
            b_q     <= b_mag;
            sa_q    <= sa_in;
            sb_q    <= sb_in;
            cnt_q   <= '0;
            acc_q   <= {{WIDTH{1'b0}}, (op_is_div(op) ? a_mag : b_mag)};
            busy_q  <= 1'b1;
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= ST_FIX;
        end
        ST_FIX: begin
          hilo_q  <= result;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          hilo_we_q <= 1'b1;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign hilo_we = hilo_we_q;
  assign hilo_o  = hilo_q;

endmodule

// File: tb/tb_muldiv.sv
// Randomized self-checking bench for muldiv against an arithmetic reference model.
module tb_muldiv;

  logic        clk = 1'b0;
  logic        rst, start, cancel;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, hilo_we;
  logic [63:0] hilo_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .hilo_we(hilo_we), .hilo_o(hilo_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: res = 64'(sx * sy);
      2'b01: res = {32'b0, x} * {32'b0, y};
      2'b10: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else        res = {x % y, x / y};
      end
    endcase
    return res;
  endfunction

  // Launch one op, scramble inputs after acceptance, optionally re-pulse start
  // while busy, then check latency, single strobe, busy profile and result.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int repulse);
    logic [63:0] exp, got;
    int          we_edge, we_cnt;
    logic        busy1, busy_we, busy_end;
    exp     = model(o, x, y);
    we_edge = -1;
    we_cnt  = 0;
    got     = '0;
    busy_we = 1'b0;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    busy1 = busy;
    for (int n = 1; n <= 40; n++) begin
      if (n == repulse) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (hilo_we) begin
        if (we_edge < 0) begin
          we_edge = n;
          got     = hilo_o;
          busy_we = busy;
        end
        we_cnt++;
      end
    end
    busy_end = busy;
    check({tag, " result"},  got, exp);
    check({tag, " latency"}, 64'(we_edge), 64'd34);
    check({tag, " we_count"}, 64'(we_cnt), 64'd1);
    check({tag, " busy_start"}, 64'(busy1), 64'd1);
    check({tag, " busy_at_we"}, 64'(busy_we), 64'd1);
    check({tag, " busy_end"}, 64'(busy_end), 64'd0);
  endtask

  task automatic count_writes(input int cycles, output int wes);
    wes = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk); #1;
      if (hilo_we) wes++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          wes;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset we",   64'(hilo_we), 64'd0);
    check("reset hilo", hilo_o, 64'd0);
    rst = 1'b0;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("multu_max const", model(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7, 0);
    run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("divu_zero", 2'b11, 32'd5, 32'd0, 0);
    run_op("div_zero",  2'b10, 32'hFFFF_FFFB, 32'd0, 0);
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("mult_min",  2'b00, 32'h8000_0000, 32'h8000_0000, 0);
    run_op("repulse",   2'b01, 32'd1234, 32'd5678, 7);

    // Cancel on edge 10 of a DIVU, then an immediate restart.
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    check("cancel busy", 64'(busy), 64'd0);
    check("cancel we",   64'(hilo_we), 64'd0);
    run_op("after_cancel", 2'b11, 32'd1000, 32'd33, 0);

    // Cancel beats start in IDLE.
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    check("cancel_vs_start busy", 64'(busy), 64'd0);
    count_writes(40, wes);
    check("cancel_vs_start writes", 64'(wes), 64'd0);

    // Re-pulse while busy, then reset on edge 20.
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    wes = 0;
    for (int n = 1; n <= 19; n++) begin
      if (n == 5) begin start = 1'b1; op = 2'b10; end
      @(posedge clk); #1;
      start = 1'b0;
      if (hilo_we) wes++;
    end
    check("pre_reset busy", 64'(busy), 64'd1);
    rst = 1'b1; start = 1'b1; cancel = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; cancel = 1'b0;
    check("mid_reset busy", 64'(busy), 64'd0);
    check("mid_reset we",   64'(hilo_we), 64'd0);
    check("mid_reset hilo", hilo_o, 64'd0);
    count_writes(40, wes);
    check("mid_reset writes", 64'(wes), 64'd0);

    for (int i = 0; i < 20; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = (i % 5 == 4) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      if (i % 4 == 1) ra = 32'($urandom_range(0, 1000));
      run_op("random", ro, ra, rb, (i % 2 == 0) ? 10 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
